// File: rtl/rr_stream_arbiter.sv
// Packet-aware round-robin arbiter: NUM_REQ valid/ready producers share one
// registered valid/ready output stage that also carries the source index.

module rr_arb_lane #(
   parameter int ID_W = 2,
   parameter int LANE = 0
) (
   input  logic            rst_n,
   input  logic            can_accept,
   input  logic            found,
   input  logic [ID_W-1:0] grant,
   output logic            ready
);
   assign ready = rst_n & can_accept & found & (grant == ID_W'(LANE));
endmodule

module rr_stream_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 8,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       in_valid,
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]       in_last,
   output logic [NUM_REQ-1:0]       in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_last,
   output logic [ID_W-1:0]          out_id,
   input  logic                     out_ready
);
   typedef struct packed {
      logic             vld;
      logic             last;
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
   } beat_t;

   beat_t                           out_q;
   logic [ID_W-1:0]                 rr_ptr, lock_id, grant;
   logic                            locked, found, can_accept, xfer;
   logic [ID_W:0]                   idx;
   logic [NUM_REQ-1:0][WIDTH-1:0]   data_arr;

   assign data_arr   = in_data;
   assign can_accept = ~out_q.vld | out_ready;
   assign xfer       = |(in_valid & in_ready);

   // Rotating search from rr_ptr; a held lock overrides it entirely.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
         if (!found && in_valid[idx[ID_W-1:0]]) begin
            found = 1'b1;
            grant = idx[ID_W-1:0];
         end
      end
      if (locked) begin
         grant = lock_id;
         found = in_valid[lock_id];
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      rr_arb_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
         .rst_n      (rst_n),
         .can_accept (can_accept),
         .found      (found),
         .grant      (grant),
         .ready      (in_ready[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         rr_ptr  <= '0;
         locked  <= 1'b0;
         lock_id <= '0;
      end else if (xfer) begin
         out_q <= '{vld: 1'b1, last: in_last[grant], id: grant, data: data_arr[grant]};
         if (in_last[grant]) begin
            locked <= 1'b0;
            rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
         end else begin
            locked  <= 1'b1;
            lock_id <= grant;
         end
      end else if (out_ready) begin
         out_q.vld <= 1'b0;
      end
   end

   assign out_valid = out_q.vld;
   assign out_data  = out_q.data;
   assign out_last  = out_q.last;
   assign out_id    = out_q.id;
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: round-robin order, packet lock,
// idle gaps while locked, backpressure and asynchronous reset.

module tb_rr_stream_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     in_valid, in_last, in_ready;
   logic [N*W-1:0]   in_data;
   logic             out_valid, out_last, out_ready;
   logic [W-1:0]     out_data;
   logic [1:0]       out_id;

   int n_cmp  = 0;
   int n_fail = 0;

   rr_stream_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_id(out_id),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int lane, input logic [W-1:0] d);
      in_data[lane*W +: W] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; in_data = '0; out_ready = 1'b1;
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got %b want 0000", in_ready); end
      n_cmp++; if (out_id !== 2'd0 || out_data !== 8'h00 || out_last !== 1'b0) begin
         n_fail++; $display("FAIL rst_regs got id=%0d data=%h last=%b want 0/00/0", out_id, out_data, out_last); end
      cyc();
      in_valid = 4'b0000;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready c%0d got %b want 0000", c, in_ready); end
         cyc();
         n_cmp++; if (out_valid !== 1'b0 || out_id !== 2'd0) begin
            n_fail++; $display("FAIL idle_out c%0d got v=%b id=%0d want 0/0", c, out_valid, out_id); end
      end
   endtask

   task automatic test_rr_single();
      int exp_id[6] = '{0, 1, 2, 3, 0, 1};
      logic [3:0] r;
      for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
      in_last = 4'b1111; in_valid = 4'b1111;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_lat got %b want 0", out_valid); end
      for (int c = 0; c < 6; c++) begin
         r = 4'b0001 << exp_id[c];
         n_cmp++; if (in_ready !== r) begin n_fail++; $display("FAIL rr_ready c%0d got %b want %b", c, in_ready, r); end
         cyc();
         n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'(exp_id[c]) || out_data !== 8'h10 + 8'(exp_id[c])) begin
            n_fail++; $display("FAIL rr_out c%0d got v=%b id=%0d d=%h want 1/%0d/%h",
                               c, out_valid, out_id, out_data, exp_id[c], 8'h10 + 8'(exp_id[c])); end
      end
      in_valid = 4'b0000;
      cyc();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b want 0", out_valid); end
   endtask

   task automatic test_lock();
      // req0 single beat moves rr_ptr from 2 to 1
      in_valid = 4'b0001; in_last = 4'b0001; set_data(0, 8'h01);
      cyc();
      in_valid = 4'b0111;
      for (int b = 0; b < 3; b++) begin
         in_last = (b == 2) ? 4'b0111 : 4'b0101;
         set_data(1, 8'h21 + 8'(b));
         #1;
         n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_ready b%0d got %b want 0010", b, in_ready); end
         cyc();
         n_cmp++; if (out_id !== 2'd1 || out_data !== 8'h21 + 8'(b) || out_last !== (b == 2)) begin
            n_fail++; $display("FAIL lock_out b%0d got id=%0d d=%h l=%b want 1/%h/%b",
                               b, out_id, out_data, out_last, 8'h21 + 8'(b), b == 2); end
      end
      n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_next got %b want 0100", in_ready); end
      cyc();
      n_cmp++; if (out_id !== 2'd2) begin n_fail++; $display("FAIL lock_next_id got %0d want 2", out_id); end
      in_valid = 4'b0000;
      cyc();
   endtask

   task automatic test_gap();
      in_valid = 4'b1001; in_last = 4'b0001; set_data(3, 8'h31); set_data(0, 8'h00);
      #1;
      n_cmp++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL gap_first got %b want 1000", in_ready); end
      cyc();
      n_cmp++; if (out_id !== 2'd3 || out_data !== 8'h31) begin
         n_fail++; $display("FAIL gap_b0 got id=%0d d=%h want 3/31", out_id, out_data); end
      in_valid = 4'b0001;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL gap_ready c%0d got %b want 0000", c, in_ready); end
         cyc();
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_out c%0d got %b want 0", c, out_valid); end
      end
      in_valid = 4'b1001; in_last = 4'b1001; set_data(3, 8'h32);
      #1;
      n_cmp++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL gap_resume got %b want 1000", in_ready); end
      cyc();
      n_cmp++; if (out_id !== 2'd3 || out_data !== 8'h32 || out_last !== 1'b1) begin
         n_fail++; $display("FAIL gap_b1 got id=%0d d=%h l=%b want 3/32/1", out_id, out_data, out_last); end
      n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL gap_wrap got %b want 0001", in_ready); end
      cyc();
      n_cmp++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL gap_wrap_id got %0d want 0", out_id); end
      in_valid = 4'b0000;
      cyc();
   endtask

   task automatic test_backpressure();
      in_valid = 4'b0100; in_last = 4'b0000; set_data(2, 8'hA5);
      #1;
      n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_first got %b want 0100", in_ready); end
      cyc();
      out_ready = 1'b0; in_last = 4'b0100; set_data(2, 8'h5A);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready c%0d got %b want 0000", c, in_ready); end
         cyc();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_fail++; $display("FAIL bp_hold c%0d got v=%b d=%h want 1/a5", c, out_valid, out_data); end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release got %b want 0100", in_ready); end
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_last !== 1'b1 || out_id !== 2'd2) begin
         n_fail++; $display("FAIL bp_next got v=%b d=%h l=%b id=%0d want 1/5a/1/2", out_valid, out_data, out_last, out_id); end
      in_valid = 4'b0000;
      cyc();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got %b want 0", out_valid); end
   endtask

   task automatic test_async_reset();
      in_valid = 4'b0010; in_last = 4'b0000; set_data(1, 8'h77);
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin
         n_fail++; $display("FAIL ar_pre got v=%b id=%0d want 1/1", out_valid, out_id); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_drop got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_ready got %b want 0000", in_ready); end
      in_valid = 4'b1111; in_last = 4'b1111;
      #1 rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first got %b want 0001", in_ready); end
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin
         n_fail++; $display("FAIL ar_out got v=%b id=%0d want 1/0", out_valid, out_id); end
      in_valid = 4'b0000;
      cyc();
   endtask

   initial begin
      test_reset();
      test_rr_single();
      test_lock();
      test_gap();
      test_backpressure();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
